// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the register-operation sequencer.
//   - opcode constants OP_MOV..OP_NOT (3-bit)
//   - register index constants AL, BL, CL, DL (2-bit)
//   - sequencer FSM state encoding
//   - helper that widens a 2-bit register index to the 8-bit select bus
package cpu_pkg;

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_CMP = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  localparam logic [1:0] AL = 2'd0;
  localparam logic [1:0] BL = 2'd1;
  localparam logic [1:0] CL = 2'd2;
  localparam logic [1:0] DL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  // The register file select buses are 8 bits wide; only 4 entries exist.
  function automatic logic [7:0] idx_to_select(input logic [1:0] idx);
    return {6'b000000, idx};
  endfunction

endpackage

// File: rtl/reg_op_alu.sv
// reg_op_alu: combinational 8-bit ALU for the register-operation sequencer.
// Ports:
//   op     in  3  opcode (cpu_pkg OP_*)
//   a      in  8  first operand (destination register value)
//   b      in  8  second operand (source register or immediate)
//   result out 8  operation result, modulo 256 (MOV passes b through)
//   z      out 1  result == 0
//   c      out 1  carry for ADD, borrow for SUB/CMP, 0 otherwise
module reg_op_alu
  import cpu_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result,
  output logic       z,
  output logic       c
);

  logic [8:0] sum;
  logic [8:0] diff;

  // Bit 8 of the 9-bit difference is set exactly when a < b (unsigned borrow).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = b;
    c      = 1'b0;
    case (op)
      OP_MOV: result = b;
      OP_ADD: {c, result} = sum;
      OP_SUB: {c, result} = diff;
      OP_CMP: {c, result} = diff;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      default: result = b;
    endcase
  end

  assign z = (result == 8'h00);

endmodule

// File: rtl/reg_op_seq.sv
// reg_op_seq: multi-cycle sequencer executing one two-operand instruction
// against a 4-entry 8-bit register file with one combinational read port and
// one clocked write port. Operands are read one per cycle, the ALU result and
// flags are registered in EXEC, and the result is written back in WB.
// Ports:
//   clk           in  1  clock, rising edge
//   reset         in  1  asynchronous, active-high
//   start         in  1  execute request, sampled only while idle
//   op            in  3  opcode (MOV ADD SUB AND OR XOR CMP NOT)
//   dst           in  2  destination / first operand register index
//   src           in  2  second operand register index
//   imm           in  8  immediate second operand
//   use_imm       in  1  second operand is imm, source read skipped
//   reg_r_line    in  8  register file read data (same cycle as reg_r)
//   reg_r         out 1  register file read enable
//   reg_r_select  out 8  read index, bits [7:2] zero
//   reg_w         out 1  register file write enable
//   reg_w_select  out 8  write index, bits [7:2] zero
//   reg_w_line    out 8  write data
//   busy          out 1  high whenever not idle
//   done          out 1  one-cycle pulse in the final cycle of an instruction
//   flag_z        out 1  registered zero flag
//   flag_c        out 1  registered carry/borrow flag
module reg_op_seq
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [1:0] dst,
  input  logic [1:0] src,
  input  logic [7:0] imm,
  input  logic       use_imm,
  input  logic [7:0] reg_r_line,
  output logic       reg_r,
  output logic [7:0] reg_r_select,
  output logic       reg_w,
  output logic [7:0] reg_w_select,
  output logic [7:0] reg_w_line,
  output logic       busy,
  output logic       done,
  output logic       flag_z,
  output logic       flag_c
);

  state_t     state;
  state_t     state_next;

  logic [2:0] op_q;
  logic [1:0] dst_q;
  logic [1:0] src_q;
  logic       use_imm_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] result_q;

  logic [7:0] alu_result;
  logic       alu_z;
  logic       alu_c;

  reg_op_alu u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    reg_r        = 1'b0;
    reg_r_select = 8'h00;
    reg_w        = 1'b0;
    reg_w_select = 8'h00;
    reg_w_line   = 8'h00;
    done         = 1'b0;
    busy         = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (start) begin
          // MOV never needs the destination's old value.
          if (op != OP_MOV)  state_next = ST_RD_A;
          else if (use_imm)  state_next = ST_EXEC;
          else               state_next = ST_RD_B;
        end
      end
      ST_RD_A: begin
        reg_r        = 1'b1;
        reg_r_select = idx_to_select(dst_q);
        if (use_imm_q || op_q == OP_NOT) state_next = ST_EXEC;
        else                             state_next = ST_RD_B;
      end
      ST_RD_B: begin
        reg_r        = 1'b1;
        reg_r_select = idx_to_select(src_q);
        state_next   = ST_EXEC;
      end
      ST_EXEC: begin
        // CMP only updates flags, so it finishes here without a write.
        if (op_q == OP_CMP) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_WB: begin
        reg_w        = 1'b1;
        reg_w_select = idx_to_select(dst_q);
        reg_w_line   = result_q;
        done         = 1'b1;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= OP_MOV;
      dst_q     <= AL;
      src_q     <= AL;
      use_imm_q <= 1'b0;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      result_q  <= 8'h00;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q      <= op;
            dst_q     <= dst;
            src_q     <= src;
            use_imm_q <= use_imm;
            // Preload the immediate; a source read in RD_B overwrites it.
            b_q       <= imm;
          end
        end
        ST_RD_A: a_q <= reg_r_line;
        ST_RD_B: b_q <= reg_r_line;
        ST_EXEC: begin
          result_q <= alu_result;
          if (op_q != OP_MOV) begin
            flag_z <= alu_z;
            flag_c <= alu_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_op_seq.sv
module tb_reg_op_seq;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [1:0] dst;
  logic [1:0] src;
  logic [7:0] imm;
  logic       use_imm;
  logic [7:0] reg_r_line;
  logic       reg_r;
  logic [7:0] reg_r_select;
  logic       reg_w;
  logic [7:0] reg_w_select;
  logic [7:0] reg_w_line;
  logic       busy;
  logic       done;
  logic       flag_z;
  logic       flag_c;

  always #5 clk = ~clk;

  reg_op_seq dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .dst          (dst),
    .src          (src),
    .imm          (imm),
    .use_imm      (use_imm),
    .reg_r_line   (reg_r_line),
    .reg_r        (reg_r),
    .reg_r_select (reg_r_select),
    .reg_w        (reg_w),
    .reg_w_select (reg_w_select),
    .reg_w_line   (reg_w_line),
    .busy         (busy),
    .done         (done),
    .flag_z       (flag_z),
    .flag_c       (flag_c)
  );

  // Register file attached to the DUT ports.
  logic [7:0] rf [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  int         wr_count = 0;

  assign reg_r_line = rf[reg_r_select[1:0]];

  always @(posedge clk) begin
    if (reg_w) begin
      rf[reg_w_select[1:0]] <= reg_w_line;
      wr_count <= wr_count + 1;
    end
  end

  // Reference model state.
  logic [7:0] m_rf [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic       m_z = 1'b0;
  logic       m_c = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-cycle observations; index k = cycles after the start cycle.
  logic       obs_rd    [10];
  logic [7:0] obs_rsel  [10];
  logic       obs_wr    [10];
  logic [7:0] obs_wsel  [10];
  logic [7:0] obs_wline [10];
  logic       obs_done  [10];
  logic       obs_busy  [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Architectural effect of one instruction, updating the model state.
  task automatic predict_commit(input logic [2:0] o, input logic [1:0] d, input logic [1:0] s,
                                input logic [7:0] im, input logic ui, output logic [7:0] r);
    int a, b, x;
    logic cy;
    a  = int'(m_rf[d]);
    b  = ui ? int'(im) : int'(m_rf[s]);
    cy = 1'b0;
    case (o)
      OP_MOV: x = b;
      OP_ADD: begin x = a + b; cy = (x > 255); end
      OP_SUB, OP_CMP: begin x = a - b; cy = (a < b); end
      OP_AND: x = a & b;
      OP_OR:  x = a | b;
      OP_XOR: x = a ^ b;
      default: x = 255 - a;
    endcase
    r = x[7:0];
    if (o != OP_CMP) m_rf[d] = r;
    if (o != OP_MOV) begin
      m_z = (r == 8'h00);
      m_c = cy;
    end
  endtask

  task automatic sample(input int k);
    obs_rd[k]    = reg_r;
    obs_rsel[k]  = reg_r_select;
    obs_wr[k]    = reg_w;
    obs_wsel[k]  = reg_w_select;
    obs_wline[k] = reg_w_line;
    obs_done[k]  = done;
    obs_busy[k]  = busy;
  endtask

  // Issue one start and record 10 cycles. At cycle pulse_k a second start
  // (ADD BL,#1) is presented; otherwise inputs are scrambled with start low.
  task automatic exec_instr(input logic [2:0] o, input logic [1:0] d, input logic [1:0] s,
                            input logic [7:0] im, input logic ui, input int pulse_k);
    @(posedge clk); #1;
    op = o; dst = d; src = s; imm = im; use_imm = ui; start = 1'b1;
    @(negedge clk); sample(0);
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == pulse_k) begin
        start = 1'b1; op = OP_ADD; dst = BL; src = AL; imm = 8'h01; use_imm = 1'b1;
      end else begin
        start = 1'b0; op = 3'($urandom_range(0, 7)); dst = 2'($urandom_range(0, 3));
        src = 2'($urandom_range(0, 3)); imm = 8'($urandom); use_imm = 1'($urandom_range(0, 1));
      end
      @(negedge clk); sample(k);
    end
    start = 1'b0;
  endtask

  task automatic load_reg(input logic [1:0] d, input logic [7:0] v);
    logic [7:0] r;
    predict_commit(OP_MOV, d, AL, v, 1'b1, r);
    exec_instr(OP_MOV, d, AL, v, 1'b1, -1);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 3'd0; dst = 2'd0; src = 2'd0; imm = 8'h00; use_imm = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({reg_r, reg_r_select, reg_w, reg_w_select, reg_w_line, busy, done, flag_z, flag_c} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got r=%b rsel=%h w=%b wsel=%h wline=%h busy=%b done=%b z=%b c=%b, expected all 0",
               reg_r, reg_r_select, reg_w, reg_w_select, reg_w_line, busy, done, flag_z, flag_c);
    end
    reset = 1'b0;
  endtask

  task automatic test_mov_imm;
    logic [7:0] r;
    predict_commit(OP_MOV, AL, BL, 8'h5A, 1'b1, r);
    exec_instr(OP_MOV, AL, BL, 8'h5A, 1'b1, -1);
    n_tests++;
    if ({obs_wr[2], obs_wsel[2], obs_wline[2], obs_done[2]} !== {1'b1, 8'h00, 8'h5A, 1'b1}) begin
      n_fail++;
      $display("FAIL mov_imm_wb: got w=%b wsel=%h wline=%h done=%b, expected 1 00 5a 1",
               obs_wr[2], obs_wsel[2], obs_wline[2], obs_done[2]);
    end
    n_tests++;
    if ({obs_rd[1], obs_rd[2], obs_wr[1], obs_done[1], obs_busy[3]} !== 5'b0) begin
      n_fail++;
      $display("FAIL mov_imm_noread: got rd1=%b rd2=%b w1=%b done1=%b busy3=%b, expected all 0",
               obs_rd[1], obs_rd[2], obs_wr[1], obs_done[1], obs_busy[3]);
    end
    n_tests++;
    if ({rf[0], flag_z, flag_c} !== {8'h5A, 2'b00}) begin
      n_fail++;
      $display("FAIL mov_imm_state: got AL=%h z=%b c=%b, expected 5a 0 0", rf[0], flag_z, flag_c);
    end
  endtask

  task automatic test_add;
    logic [7:0] r;
    load_reg(AL, 8'hF0);
    load_reg(BL, 8'h20);
    predict_commit(OP_ADD, AL, BL, 8'h00, 1'b0, r);
    exec_instr(OP_ADD, AL, BL, 8'h00, 1'b0, -1);
    n_tests++;
    if ({obs_rd[1], obs_rsel[1], obs_rd[2], obs_rsel[2]} !== {1'b1, 8'h00, 1'b1, 8'h01}) begin
      n_fail++;
      $display("FAIL add_reads: got rd1=%b sel1=%h rd2=%b sel2=%h, expected 1 00 1 01",
               obs_rd[1], obs_rsel[1], obs_rd[2], obs_rsel[2]);
    end
    n_tests++;
    if ({obs_wr[3], obs_done[3], obs_wr[4], obs_wsel[4], obs_wline[4], obs_done[4]}
        !== {1'b0, 1'b0, 1'b1, 8'h00, 8'h10, 1'b1}) begin
      n_fail++;
      $display("FAIL add_wb: got w3=%b d3=%b w4=%b wsel=%h wline=%h d4=%b, expected 0 0 1 00 10 1",
               obs_wr[3], obs_done[3], obs_wr[4], obs_wsel[4], obs_wline[4], obs_done[4]);
    end
    n_tests++;
    if ({rf[0], flag_z, flag_c} !== {8'h10, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL add_state: got AL=%h z=%b c=%b, expected 10 0 1", rf[0], flag_z, flag_c);
    end
  endtask

  task automatic test_cmp_same;
    logic [7:0] r;
    int wrc;
    load_reg(CL, 8'h33);
    wrc = wr_count;
    predict_commit(OP_CMP, CL, CL, 8'h00, 1'b0, r);
    exec_instr(OP_CMP, CL, CL, 8'h00, 1'b0, -1);
    n_tests++;
    if ({obs_rd[1], obs_rsel[1], obs_rd[2], obs_rsel[2], obs_done[3], obs_busy[4]}
        !== {1'b1, 8'h02, 1'b1, 8'h02, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL cmp_timing: got rd1=%b sel1=%h rd2=%b sel2=%h done3=%b busy4=%b, expected 1 02 1 02 1 0",
               obs_rd[1], obs_rsel[1], obs_rd[2], obs_rsel[2], obs_done[3], obs_busy[4]);
    end
    n_tests++;
    if ({wr_count - wrc, rf[2], flag_z, flag_c} !== {32'd0, 8'h33, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL cmp_state: got writes=%0d CL=%h z=%b c=%b, expected 0 33 1 0",
               wr_count - wrc, rf[2], flag_z, flag_c);
    end
  endtask

  task automatic test_not;
    logic [7:0] r;
    load_reg(DL, 8'hFF);
    predict_commit(OP_NOT, DL, AL, 8'h00, 1'b0, r);
    exec_instr(OP_NOT, DL, AL, 8'h00, 1'b0, -1);
    n_tests++;
    if ({obs_rd[1], obs_rsel[1], obs_rd[2], obs_wr[2]} !== {1'b1, 8'h03, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL not_reads: got rd1=%b sel1=%h rd2=%b w2=%b, expected 1 03 0 0",
               obs_rd[1], obs_rsel[1], obs_rd[2], obs_wr[2]);
    end
    n_tests++;
    if ({obs_wr[3], obs_wsel[3], obs_wline[3], obs_done[3], flag_z, flag_c}
        !== {1'b1, 8'h03, 8'h00, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL not_wb: got w=%b wsel=%h wline=%h done=%b z=%b c=%b, expected 1 03 00 1 1 0",
               obs_wr[3], obs_wsel[3], obs_wline[3], obs_done[3], flag_z, flag_c);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] r;
    int wrc;
    load_reg(AL, 8'h11);
    load_reg(BL, 8'h22);
    wrc = wr_count;
    predict_commit(OP_ADD, AL, BL, 8'h00, 1'b0, r);
    exec_instr(OP_ADD, AL, BL, 8'h00, 1'b0, 2);
    n_tests++;
    if ({wr_count - wrc, obs_wline[4], obs_busy[4], obs_busy[5], rf[1]}
        !== {32'd1, 8'h33, 1'b1, 1'b0, 8'h22}) begin
      n_fail++;
      $display("FAIL busy_ignore: got writes=%0d wline=%h busy4=%b busy5=%b BL=%h, expected 1 33 1 0 22",
               wr_count - wrc, obs_wline[4], obs_busy[4], obs_busy[5], rf[1]);
    end
    wrc = wr_count;
    predict_commit(OP_ADD, AL, BL, 8'h00, 1'b0, r);
    predict_commit(OP_ADD, BL, AL, 8'h01, 1'b1, r);
    exec_instr(OP_ADD, AL, BL, 8'h00, 1'b0, 5);
    n_tests++;
    if ({obs_wr[8], obs_wsel[8], obs_wline[8], obs_done[8], wr_count - wrc}
        !== {1'b1, 8'h01, 8'h23, 1'b1, 32'd2}) begin
      n_fail++;
      $display("FAIL start_after_done: got w8=%b wsel=%h wline=%h done8=%b writes=%0d, expected 1 01 23 1 2",
               obs_wr[8], obs_wsel[8], obs_wline[8], obs_done[8], wr_count - wrc);
    end
    n_tests++;
    if ({rf[0], rf[1], flag_z, flag_c} !== {m_rf[0], m_rf[1], m_z, m_c}) begin
      n_fail++;
      $display("FAIL b2b_state: got AL=%h BL=%h z=%b c=%b, expected %h %h %b %b",
               rf[0], rf[1], flag_z, flag_c, m_rf[0], m_rf[1], m_z, m_c);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] r;
    int wrc;
    load_reg(AL, 8'h10);
    predict_commit(OP_CMP, AL, AL, 8'h20, 1'b1, r);
    exec_instr(OP_CMP, AL, AL, 8'h20, 1'b1, -1);
    load_reg(BL, 8'h05);
    n_tests++;
    if ({flag_z, flag_c} !== 2'b01) begin
      n_fail++;
      $display("FAIL resetmid_pre_flags: got z=%b c=%b, expected 0 1", flag_z, flag_c);
    end
    wrc = wr_count;
    @(posedge clk); #1;
    op = OP_SUB; dst = AL; src = BL; imm = 8'h00; use_imm = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, reg_r, reg_w, done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL resetmid_exec: got busy=%b r=%b w=%b done=%b, expected 1 0 0 0", busy, reg_r, reg_w, done);
    end
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if ({reg_r, reg_r_select, reg_w, reg_w_select, reg_w_line, busy, done, flag_z, flag_c} !== 30'd0) begin
      n_fail++;
      $display("FAIL resetmid_outputs: got r=%b w=%b wline=%h busy=%b done=%b z=%b c=%b, expected all 0",
               reg_r, reg_w, reg_w_line, busy, done, flag_z, flag_c);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_z = 1'b0;
    m_c = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({wr_count - wrc, rf[0], busy} !== {32'd0, 8'h10, 1'b0}) begin
      n_fail++;
      $display("FAIL resetmid_after: got writes=%0d AL=%h busy=%b, expected 0 10 0", wr_count - wrc, rf[0], busy);
    end
    predict_commit(OP_XOR, AL, BL, 8'hFF, 1'b1, r);
    exec_instr(OP_XOR, AL, BL, 8'hFF, 1'b1, -1);
    n_tests++;
    if ({obs_wr[3], obs_wsel[3], obs_wline[3], rf[0], flag_z, flag_c}
        !== {1'b1, 8'h00, 8'hEF, 8'hEF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL resetmid_next: got w=%b wsel=%h wline=%h AL=%h z=%b c=%b, expected 1 00 ef ef 0 0",
               obs_wr[3], obs_wsel[3], obs_wline[3], rf[0], flag_z, flag_c);
    end
  endtask

  task automatic test_random;
    logic [2:0] o;
    logic [1:0] d, s;
    logic [7:0] im, r;
    logic       ui;
    logic [1:0] rq[$];
    int         dc;
    logic [27:0] got, expv;
    for (int it = 0; it < 40; it++) begin
      o  = 3'($urandom_range(0, 7));
      d  = 2'($urandom_range(0, 3));
      s  = 2'($urandom_range(0, 3));
      im = 8'($urandom);
      ui = 1'($urandom_range(0, 1));
      rq.delete();
      if (o != OP_MOV) rq.push_back(d);
      if (!ui && o != OP_NOT) rq.push_back(s);
      dc = rq.size() + 1 + ((o != OP_CMP) ? 1 : 0);
      predict_commit(o, d, s, im, ui, r);
      exec_instr(o, d, s, im, ui, -1);
      for (int k = 0; k < 10; k++) begin
        expv = '0;
        if (k >= 1 && k <= rq.size()) expv[27:19] = {1'b1, 6'b0, rq[k-1]};
        if (k == dc && o != OP_CMP) expv[18:2] = {1'b1, 6'b0, d, r};
        expv[1] = (k == dc);
        expv[0] = (k >= 1 && k <= dc);
        got = {obs_rd[k], obs_rsel[k], obs_wr[k], obs_wsel[k], obs_wline[k], obs_done[k], obs_busy[k]};
        n_tests++;
        if (got !== expv) begin
          n_fail++;
          $display("FAIL rand_cycle it=%0d op=%0d d=%0d s=%0d ui=%b k=%0d: got %h, expected %h",
                   it, o, d, s, ui, k, got, expv);
        end
      end
      n_tests++;
      if ({rf[0], rf[1], rf[2], rf[3], flag_z, flag_c} !== {m_rf[0], m_rf[1], m_rf[2], m_rf[3], m_z, m_c}) begin
        n_fail++;
        $display("FAIL rand_state it=%0d op=%0d: got rf=%h %h %h %h z=%b c=%b, expected %h %h %h %h %b %b",
                 it, o, rf[0], rf[1], rf[2], rf[3], flag_z, flag_c,
                 m_rf[0], m_rf[1], m_rf[2], m_rf[3], m_z, m_c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp_same();
    test_not();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
